max7219_ctrl: RTL and testbench

Word-level scheduler and SPI driver for a MAX7219 8-digit LED controller. After reset it runs the fixed power-up register sequence. It then keeps an internal 8-entry digit buffer mirrored into the chip by sending only changed digits, and it arbitrates raw register writes from a host port against that refresh traffic. It sits between user logic and the MAX7219 pins (DIN, CLK, LOAD/CS), replacing hand-sequenced per-register state machines.

---
 rtl/max7219_ctrl.sv | 171 +++++++++++++++++
 tb/tb_max7219_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_ctrl.sv
// MAX7219 word scheduler and SPI driver: runs the power-up register sequence, then
// mirrors an 8-digit buffer into the chip (changed digits only) and arbitrates host writes.
module max7219_ctrl #(
  parameter int unsigned CLK_DIV   = 25,
  parameter logic [3:0]  INTENSITY = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic       req,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       ack,
  output logic       spi_clk,
  output logic       dout,
  output logic       cs,
  output logic       init_done,
  output logic       busy
);

  localparam logic [8:0] DIV_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] DIV_HALF = 9'(CLK_DIV);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SHIFT, S_GAP} state_e;

  state_e      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [8:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [2:0]  init_cnt_q, init_cnt_d;
  logic        init_done_q, init_done_d;
  logic        ack_q, ack_d;
  logic [7:0]  dirty_q, dirty_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [7:0]  buf_q [8];
  logic [7:0]  buf_d [8];

  logic [15:0] init_word;
  logic        sel_vld;
  logic [2:0]  sel_idx;
  logic [2:0]  cand;

  always_comb begin
    case (init_cnt_q)
      3'd0:    init_word = 16'h0F00;
      3'd1:    init_word = 16'h0B07;
      3'd2:    init_word = 16'h09FF;
      3'd3:    init_word = {8'h0A, 4'h0, INTENSITY};
      default: init_word = 16'h0C01;
    endcase
  end

  // Round-robin scan: first dirty digit at or after the pointer, wrapping 7->0.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = ptr_q;
    cand    = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!sel_vld && dirty_q[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_INIT;
      sr_q        <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      ack_q       <= 1'b0;
      dirty_q     <= '1;
      ptr_q       <= '0;
      for (int unsigned i = 0; i < 8; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      ack_q       <= ack_d;
      dirty_q     <= dirty_d;
      ptr_q       <= ptr_d;
      buf_q       <= buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    div_d       = div_q;
    bit_d       = bit_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    ack_d       = 1'b0;
    dirty_d     = dirty_q;
    ptr_d       = ptr_q;
    buf_d       = buf_q;
    unique case (state_q)
      S_INIT: begin
        sr_d    = init_word;
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (req && init_done_q) begin
          sr_d    = {req_addr, req_data};
          ack_d   = 1'b1;
          state_d = S_SHIFT;
        end else if (sel_vld) begin
          sr_d             = {8'(sel_idx) + 8'd1, buf_q[sel_idx]};
          dirty_d[sel_idx] = 1'b0;
          ptr_d            = sel_idx + 3'd1;
          state_d          = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sr_d  = {sr_q[14:0], 1'b0};
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) state_d = S_GAP;
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      S_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (init_cnt_q == 3'd4) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            init_cnt_d = init_cnt_q + 3'd1;
            state_d    = S_INIT;
          end
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      default: state_d = S_INIT;
    endcase
    // Applied after the arbitration clear so a same-cycle write keeps the digit dirty.
    if (wr_en) begin
      buf_d[wr_idx]   = wr_data;
      dirty_d[wr_idx] = 1'b1;
    end
  end

  always_comb begin
    cs        = (state_q != S_SHIFT);
    spi_clk   = (state_q == S_SHIFT) && (div_q >= DIV_HALF);
    dout      = (state_q == S_SHIFT) && sr_q[15];
    busy      = (state_q == S_SHIFT) || (state_q == S_GAP);
    ack       = ack_q;
    init_done = init_done_q;
  end

endmodule

// File: tb/tb_max7219_ctrl.sv
// Bench for max7219_ctrl: decodes the SPI pins into words and checks them against
// vector tables, hand sequences and a randomized buffer/host model.
module tb_max7219_ctrl;
  localparam int unsigned CD       = 2;
  localparam int unsigned WORD_CYC = 34 * CD + 1;

  logic       clk = 1'b0, reset = 1'b0, wr_en = 1'b0, req = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [7:0] wr_data = '0, req_addr = '0, req_data = '0;
  logic       ack, spi_clk, dout, cs, init_done, busy;

  max7219_ctrl #(.CLK_DIV(CD), .INTENSITY(4'hF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .req(req), .req_addr(req_addr), .req_data(req_data), .ack(ack),
    .spi_clk(spi_clk), .dout(dout), .cs(cs), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Pin-level decoder: a word counts only if cs rises after exactly 16 rising spi_clk edges.
  logic [15:0] words[$];
  bit          wack[$];
  int unsigned wtime[$];
  logic        cs_prev = 1'b1, sclk_prev = 1'b0, ack_start = 1'b0;
  logic [15:0] sh = '0;
  int          nbits = 0, ack_cnt = 0, ack_stray = 0;
  int unsigned t_start = 0;

  always @(negedge clk) begin
    if (cs_prev && !cs) begin
      nbits = 0; ack_start = ack; t_start = cyc;
    end else if (ack) begin
      ack_stray++;
    end
    if (ack) ack_cnt++;
    if (!cs && spi_clk && !sclk_prev) begin
      sh = {sh[14:0], dout}; nbits++;
    end
    if (cs && !cs_prev && nbits == 16) begin
      words.push_back(sh); wack.push_back(ack_start); wtime.push_back(t_start);
    end
    cs_prev = cs; sclk_prev = spi_clk;
  end

  logic [7:0]  mbuf [8];
  logic [15:0] exp_boot [13];

  typedef struct {
    logic [2:0]  idx;
    logic [7:0]  data;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log;
    words.delete(); wack.delete(); wtime.delete(); ack_cnt = 0; ack_stray = 0;
  endtask

  task automatic write_digit(input logic [2:0] idx, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = idx; wr_data = d; mbuf[idx] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic host_req(input logic [7:0] a, input logic [7:0] d, input int unsigned bound,
                          output bit got, output bit done_at_ack);
    got = 1'b0; done_at_ack = 1'b0;
    @(negedge clk);
    req = 1'b1; req_addr = a; req_data = d;
    for (int unsigned i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; done_at_ack = init_done; break; end
    end
    req = 1'b0;
  endtask

  task automatic wait_cs_low(input string nm);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (!cs) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk(nm, seen, 1'b1);
  endtask

  task automatic check_boot(input string nm);
    chk({nm, "_count"}, words.size(), 13);
    for (int i = 0; i < 13 && i < words.size(); i++) chk({nm, "_word"}, words[i], exp_boot[i]);
  endtask

  initial begin
    bit got, dn;
    int k, bad, hcnt, dcnt;
    int lastd [8];
    bit wrt [8];
    logic [15:0] wv;
    int unsigned n;

    exp_boot[0] = 16'h0F00; exp_boot[1] = 16'h0B07; exp_boot[2] = 16'h09FF;
    exp_boot[3] = 16'h0A0F; exp_boot[4] = 16'h0C01;
    for (int i = 0; i < 8; i++) begin
      exp_boot[5 + i] = {8'(i + 1), 8'h00};
      mbuf[i] = 8'h00;
    end
    tbl[0] = '{3'd3, 8'h85, 16'h0485};
    tbl[1] = '{3'd0, 8'h7F, 16'h017F};
    tbl[2] = '{3'd7, 8'h0A, 16'h080A};
    tbl[3] = '{3'd4, 8'hFF, 16'h05FF};
    tbl[4] = '{3'd1, 8'h00, 16'h0200};
    tbl[5] = '{3'd6, 8'h8C, 16'h078C};

    // Reset state, then boot sequence with timing.
    tick(3);
    chk("rst_cs", cs, 1'b1);       chk("rst_spi_clk", spi_clk, 1'b0);
    chk("rst_dout", dout, 1'b0);   chk("rst_ack", ack, 1'b0);
    chk("rst_init_done", init_done, 1'b0); chk("rst_busy", busy, 1'b0);
    clear_log();
    reset = 1'b1;
    for (k = 1; k <= 500; k++) begin
      @(negedge clk);
      if (init_done) break;
    end
    chk("init_time_ok", (k >= 5 * WORD_CYC - 1 && k <= 5 * WORD_CYC + 1), 1'b1);
    tick(8 * WORD_CYC + 20);
    check_boot("boot");
    bad = 0;
    for (int i = 1; i < wtime.size(); i++) if (wtime[i] - wtime[i - 1] != WORD_CYC) bad++;
    chk("boot_spacing_bad", bad, 0);
    chk("boot_acks", ack_cnt, 0);
    chk("idle_cs", cs, 1'b1); chk("idle_busy", busy, 1'b0);

    // Single digit writes from the vector table.
    for (int t = 0; t < 6; t++) begin
      clear_log();
      write_digit(tbl[t].idx, tbl[t].data);
      tick(WORD_CYC + 20);
      chk("vec_count", words.size(), 1);
      if (words.size() > 0) chk("vec_word", words[0], tbl[t].exp);
      chk("vec_acks", ack_cnt, 0);
      chk("vec_idle_busy", busy, 1'b0);
    end

    // Host request and digit write in the same cycle: host wins.
    clear_log();
    @(negedge clk);
    req = 1'b1; req_addr = 8'h0A; req_data = 8'h03;
    wr_en = 1'b1; wr_idx = 3'd0; wr_data = 8'h07; mbuf[0] = 8'h07;
    @(negedge clk);
    wr_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ack) begin got = 1'b1; break; end
      @(negedge clk);
    end
    req = 1'b0;
    chk("arb_ack_seen", got, 1'b1);
    tick(2 * WORD_CYC + 20);
    chk("arb_count", words.size(), 2);
    if (words.size() == 2) begin
      chk("arb_first", words[0], 16'h0A03); chk("arb_second", words[1], 16'h0107);
      chk("arb_ack_first", wack[0], 1'b1);  chk("arb_ack_second", wack[1], 1'b0);
      chk("arb_spacing", wtime[1] - wtime[0], WORD_CYC);
    end
    chk("arb_ack_cnt", ack_cnt, 1); chk("arb_ack_stray", ack_stray, 0);

    // Rewrite of idx 5 during its own SHIFT: word in flight unchanged, then resent.
    clear_log();
    write_digit(3'd5, 8'h02);
    wait_cs_low("dbl_cs_fall");
    tick(10);
    write_digit(3'd5, 8'h09);
    tick(2 * WORD_CYC + 20);
    chk("dbl_count", words.size(), 2);
    if (words.size() == 2) begin
      chk("dbl_first", words[0], 16'h0602); chk("dbl_second", words[1], 16'h0609);
    end

    // Randomized digit bursts: every written digit ends up mirrored, nothing else is sent.
    for (int r = 0; r < 6; r++) begin
      clear_log();
      for (int i = 0; i < 8; i++) wrt[i] = 1'b0;
      n = $urandom_range(1, 5);
      for (int unsigned i = 0; i < n; i++) begin
        k = $urandom_range(0, 7);
        wrt[k] = 1'b1;
        write_digit(3'(k), 8'($urandom));
        tick($urandom_range(0, 40));
      end
      tick((n + 1) * WORD_CYC + 20);
      bad = 0;
      for (int i = 0; i < 8; i++) lastd[i] = -1;
      foreach (words[w]) begin
        wv = words[w];
        if (wv[15:8] < 8'd1 || wv[15:8] > 8'd8) bad++;
        else if (!wrt[wv[15:8] - 8'd1]) bad++;
        else lastd[wv[15:8] - 8'd1] = int'(wv[7:0]);
      end
      chk("rnd_addr_bad", bad, 0);
      chk("rnd_count_ok", (words.size() >= 1 && words.size() <= n), 1'b1);
      for (int i = 0; i < 8; i++) if (wrt[i]) chk("rnd_last", lastd[i], 32'(mbuf[i]));
      chk("rnd_acks", ack_cnt, 0);
    end

    // Randomized host writes.
    for (int r = 0; r < 4; r++) begin
      logic [7:0] ra, rd;
      clear_log();
      ra = 8'($urandom); rd = 8'($urandom);
      host_req(ra, rd, 20, got, dn);
      chk("host_ack", got, 1'b1);
      tick(WORD_CYC + 20);
      chk("host_count", words.size(), 1);
      if (words.size() == 1) begin
        chk("host_word", words[0], {ra, rd}); chk("host_ack_at_cs", wack[0], 1'b1);
      end
      chk("host_ack_cnt", ack_cnt, 1);
    end

    // Reset pulled low during bit 7 of a digit word.
    write_digit(3'd2, 8'h33);
    wait_cs_low("abort_cs_fall");
    tick((15 - 7) * 2 * CD + 1);
    clear_log();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cs", cs, 1'b1); chk("abort_spi_clk", spi_clk, 1'b0);
    chk("abort_dout", dout, 1'b0); chk("abort_init_done", init_done, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) mbuf[i] = 8'h00;
    tick(13 * WORD_CYC + 20);
    check_boot("abort_boot");

    // Host request held from reset release: no ack before init completes.
    @(negedge clk);
    reset = 1'b0;
    tick(3);
    clear_log();
    reset = 1'b1;
    host_req(8'h0A, 8'h05, 2000, got, dn);
    chk("initreq_ack", got, 1'b1);
    chk("initreq_done_at_ack", dn, 1'b1);
    tick(9 * WORD_CYC + 20);
    chk("initreq_count", words.size(), 14);
    hcnt = 0; dcnt = 0; bad = 0;
    foreach (words[w]) begin
      if (w < 5) begin
        if (words[w] !== exp_boot[w] || wack[w]) bad++;
      end else if (words[w] === 16'h0A05) begin
        hcnt++;
        if (!wack[w]) bad++;
      end else if (words[w][7:0] === 8'h00 && words[w][15:8] >= 8'd1 && words[w][15:8] <= 8'd8
                   && !wack[w]) begin
        dcnt++;
      end else begin
        bad++;
      end
    end
    chk("initreq_bad", bad, 0);
    chk("initreq_host_words", hcnt, 1);
    chk("initreq_digit_words", dcnt, 8);
    chk("initreq_ack_cnt", ack_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
